// File: rtl/flip_alpha_gen.sv
// Computes alpha^p, alpha^3p, alpha^5p, alpha^7p for two flip positions over
// GF(2^6/2^8/2^10). Square-and-multiply MSB first, then three odd-power products.
module flip_alpha_gen #(
  parameter int unsigned M_MAX    = 10,
  parameter int unsigned EXP_BITS = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_code,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic [M_MAX-1:0] i_pos1,
  input  logic [M_MAX-1:0] i_pos2,
  output logic [M_MAX-1:0] o_flip_alpha_S1_1,
  output logic [M_MAX-1:0] o_flip_alpha_S3_1,
  output logic [M_MAX-1:0] o_flip_alpha_S5_1,
  output logic [M_MAX-1:0] o_flip_alpha_S7_1,
  output logic [M_MAX-1:0] o_flip_alpha_S1_2,
  output logic [M_MAX-1:0] o_flip_alpha_S3_2,
  output logic [M_MAX-1:0] o_flip_alpha_S5_2,
  output logic [M_MAX-1:0] o_flip_alpha_S7_2,
  output logic             o_flip_alpha_valid,
  output logic             o_busy
);

  localparam int unsigned BIT_W    = $clog2(EXP_BITS);
  localparam logic [1:0]  CODE_GF6 = 2'd0;
  localparam logic [1:0]  CODE_GF8 = 2'd1;
  localparam logic [1:0]  CODE_GF10 = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_EXP, S_ODD1, S_ODD2, S_ODD3, S_ODD4, S_DONE
  } state_t;

  state_t           r_state;
  logic [1:0]       r_code;
  logic [BIT_W-1:0] r_bit;
  logic [M_MAX-1:0] r_pos [2];
  logic [M_MAX-1:0] r_acc [2];
  logic [M_MAX-1:0] r_r2  [2];
  logic [M_MAX-1:0] r_r3  [2];
  logic [M_MAX-1:0] r_r5  [2];
  logic [M_MAX-1:0] r_s1  [2];
  logic [M_MAX-1:0] r_s3  [2];
  logic [M_MAX-1:0] r_s5  [2];
  logic [M_MAX-1:0] r_s7  [2];
  logic             r_valid;
  logic             r_busy;

  logic [M_MAX-1:0] w_ma [2];
  logic [M_MAX-1:0] w_mb [2];
  logic [M_MAX-1:0] w_m1 [2];
  logic [M_MAX-1:0] w_m2 [2];

  // Multiply by alpha (x) with reduction by the selected primitive polynomial.
  function automatic logic [M_MAX-1:0] xtime(input logic [M_MAX-1:0] x, input logic [1:0] c);
    logic [M_MAX-1:0] y;
    case (c)
      CODE_GF6: y = {4'b0, x[4:0], 1'b0} ^ (x[5] ? 10'h003 : 10'h000);
      CODE_GF8: y = {2'b0, x[6:0], 1'b0} ^ (x[7] ? 10'h01D : 10'h000);
      default:  y = {x[8:0], 1'b0}       ^ (x[9] ? 10'h009 : 10'h000);
    endcase
    return y;
  endfunction

  function automatic logic [M_MAX-1:0] gf_mul(input logic [M_MAX-1:0] a, input logic [M_MAX-1:0] b,
                                              input logic [1:0] c);
    logic [M_MAX-1:0] p;
    p = '0;
    for (int i = M_MAX - 1; i >= 0; i--) begin
      p = xtime(p, c);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  // One shared multiplier per datapath; the operand pair follows the phase.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      w_ma[d] = r_acc[d];
      w_mb[d] = r_acc[d];
      case (r_state)
        S_ODD2:  w_mb[d] = r_r2[d];
        S_ODD3:  begin w_ma[d] = r_r3[d]; w_mb[d] = r_r2[d]; end
        S_ODD4:  begin w_ma[d] = r_r5[d]; w_mb[d] = r_r2[d]; end
        default: ;
      endcase
      w_m1[d] = gf_mul(w_ma[d], w_mb[d], r_code);
      w_m2[d] = r_pos[d][r_bit] ? xtime(w_m1[d], r_code) : w_m1[d];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_code  <= '0;
      r_bit   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      for (int d = 0; d < 2; d++) begin
        r_pos[d] <= '0; r_acc[d] <= '0; r_r2[d] <= '0; r_r3[d] <= '0; r_r5[d] <= '0;
        r_s1[d]  <= '0; r_s3[d]  <= '0; r_s5[d] <= '0; r_s7[d] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state  <= S_EXP;
            r_code   <= (i_code == 2'd3) ? CODE_GF10 : i_code;
            r_bit    <= BIT_W'(EXP_BITS - 1);
            r_pos[0] <= i_pos1;
            r_pos[1] <= i_pos2;
            r_valid  <= 1'b0;
            r_busy   <= 1'b1;
            for (int d = 0; d < 2; d++) begin
              r_acc[d] <= M_MAX'(1);
              r_s1[d] <= '0; r_s3[d] <= '0; r_s5[d] <= '0; r_s7[d] <= '0;
            end
          end else if (i_clear && r_state == S_DONE) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            for (int d = 0; d < 2; d++) begin
              r_s1[d] <= '0; r_s3[d] <= '0; r_s5[d] <= '0; r_s7[d] <= '0;
            end
          end
        end
        default: begin
          if (i_clear) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            case (r_state)
              S_EXP: begin
                for (int d = 0; d < 2; d++) r_acc[d] <= w_m2[d];
                if (r_bit == '0) r_state <= S_ODD1;
                else             r_bit   <= r_bit - BIT_W'(1);
              end
              S_ODD1: begin
                for (int d = 0; d < 2; d++) r_r2[d] <= w_m1[d];
                r_state <= S_ODD2;
              end
              S_ODD2: begin
                for (int d = 0; d < 2; d++) r_r3[d] <= w_m1[d];
                r_state <= S_ODD3;
              end
              S_ODD3: begin
                for (int d = 0; d < 2; d++) r_r5[d] <= w_m1[d];
                r_state <= S_ODD4;
              end
              default: begin
                // Higher odd powers only exist for the GF(2^10) code.
                for (int d = 0; d < 2; d++) begin
                  r_s1[d] <= r_acc[d];
                  r_s3[d] <= r_r3[d];
                  r_s5[d] <= (r_code == CODE_GF10) ? r_r5[d] : '0;
                  r_s7[d] <= (r_code == CODE_GF10) ? w_m1[d] : '0;
                end
                r_valid <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_DONE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign o_flip_alpha_S1_1  = r_s1[0];
  assign o_flip_alpha_S3_1  = r_s3[0];
  assign o_flip_alpha_S5_1  = r_s5[0];
  assign o_flip_alpha_S7_1  = r_s7[0];
  assign o_flip_alpha_S1_2  = r_s1[1];
  assign o_flip_alpha_S3_2  = r_s3[1];
  assign o_flip_alpha_S5_2  = r_s5[1];
  assign o_flip_alpha_S7_2  = r_s7[1];
  assign o_flip_alpha_valid = r_valid;
  assign o_busy             = r_busy;

endmodule

// File: tb/tb_flip_alpha_gen.sv
// Scoreboard bench for flip_alpha_gen: driver queues hand-computed flip terms,
// a monitor checks them (and the 14-edge latency) on each rising valid.
module tb_flip_alpha_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] code;
  logic       start, clear;
  logic [9:0] pos1, pos2;
  logic [9:0] s11, s31, s51, s71, s12, s32, s52, s72;
  logic       valid, busy;

  always #5 clk = ~clk;

  flip_alpha_gen dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_code(code), .i_start(start), .i_clear(clear),
    .i_pos1(pos1), .i_pos2(pos2),
    .o_flip_alpha_S1_1(s11), .o_flip_alpha_S3_1(s31), .o_flip_alpha_S5_1(s51),
    .o_flip_alpha_S7_1(s71), .o_flip_alpha_S1_2(s12), .o_flip_alpha_S3_2(s32),
    .o_flip_alpha_S5_2(s52), .o_flip_alpha_S7_2(s72),
    .o_flip_alpha_valid(valid), .o_busy(busy)
  );

  typedef struct {
    int              start_cyc;
    logic [7:0][9:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0][9:0] mk(input logic [9:0] a0, a1, a2, a3, a4, a5, a6, a7);
    logic [7:0][9:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
    return r;
  endfunction

  function automatic logic [79:0] outs();
    return {s72, s52, s32, s12, s71, s51, s31, s11};
  endfunction

  // Monitor: compare on every rising edge of valid; outputs must be 0 while invalid.
  always @(negedge clk) begin
    if (rst_n && valid && !prev_v) begin
      chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        exp_t e;
        logic [7:0][9:0] a;
        e = q.pop_front();
        a = outs();
        chk("latency", 32'(cyc - e.start_cyc), 32'd14);
        for (int k = 0; k < 8; k++)
          chk($sformatf("term%0d", k), 32'(a[k]), 32'(e.v[k]));
      end
    end
    if (!valid) chk("zero_when_invalid", 32'(outs() == 80'd0), 32'd1);
    prev_v = valid;
  end

  // Entered at a negedge; returns at the negedge after the sampling edge.
  task automatic do_start(input logic [1:0] c, input logic [9:0] p1, input logic [9:0] p2,
                          input bit push, input logic [7:0][9:0] ev);
    exp_t e;
    code = c; pos1 = p1; pos2 = p2; start = 1'b1;
    if (push) begin
      e.start_cyc = cyc + 1;
      e.v = ev;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("valid_timeout", 32'(valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    rst_n = 1'b0; code = 2'd0; start = 1'b0; clear = 1'b0; pos1 = '0; pos2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'(outs() == 80'd0), 32'd1);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // GF(2^6): pos1=6, pos2=0; valid holds until clear
    do_start(2'd0, 10'd6, 10'd0, 1'b1, mk(10'h003, 10'h00F, 10'h0, 10'h0, 10'h001, 10'h001, 10'h0, 10'h0));
    wait_valid();
    repeat (4) @(negedge clk);
    chk("valid_hold", 32'(valid), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("valid_after_clear", 32'(valid), 32'd0);

    // GF(2^10): pos1=10, pos2=1023 (alpha^1023 = 1)
    do_start(2'd2, 10'd10, 10'd1023, 1'b1,
             mk(10'h009, 10'h249, 10'h10D, 10'h2DD, 10'h001, 10'h001, 10'h001, 10'h001));
    wait_valid();
    @(negedge clk);

    // GF(2^8): pos1=8, pos2=1; busy exactly 14 cycles
    do_start(2'd1, 10'd8, 10'd1, 1'b1, mk(10'h01D, 10'h08F, 10'h0, 10'h0, 10'h002, 10'h008, 10'h0, 10'h0));
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) bc++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(bc), 32'd14);
    chk("valid_after_busy", 32'(valid), 32'd1);

    // GF(2^6): pos1=63 wraps to 1; a start during EXP is ignored
    do_start(2'd0, 10'd63, 10'd5, 1'b1, mk(10'h001, 10'h001, 10'h0, 10'h0, 10'h020, 10'h028, 10'h0, 10'h0));
    repeat (3) @(negedge clk);
    do_start(2'd1, 10'd1, 10'd1, 1'b0, '0);
    wait_valid();
    repeat (2) @(negedge clk);
    chk("valid_hold2", 32'(valid), 32'd1);

    // Restart from DONE drops valid next cycle
    do_start(2'd2, 10'd10, 10'd2, 1'b1,
             mk(10'h009, 10'h249, 10'h10D, 10'h2DD, 10'h004, 10'h040, 10'h009, 10'h090));
    chk("restart_valid_low", 32'(valid), 32'd0);
    wait_valid();
    @(negedge clk);

    // Code 11 behaves as GF(2^10)
    do_start(2'd3, 10'd1, 10'd2, 1'b1,
             mk(10'h002, 10'h008, 10'h020, 10'h080, 10'h004, 10'h040, 10'h009, 10'h090));
    wait_valid();
    @(negedge clk);

    // Clear at cycle 5 of a run aborts it
    do_start(2'd0, 10'd1, 10'd1, 1'b0, '0);
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid) bc++;
      @(negedge clk);
    end
    chk("abort_never_valid", 32'(bc), 32'd0);

    // Reset during ODD2 (state after edge 11), then a normal run
    do_start(2'd2, 10'd10, 10'd2, 1'b0, '0);
    repeat (11) @(negedge clk);
    chk("busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_outs", 32'(outs() == 80'd0), 32'd1);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_valid", 32'(valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(2'd1, 10'd8, 10'd1, 1'b1, mk(10'h01D, 10'h08F, 10'h0, 10'h0, 10'h002, 10'h008, 10'h0, 10'h0));
    wait_valid();
    repeat (2) @(negedge clk);

    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flip_alpha_gen.md
Name: flip_alpha_gen

Overview:
- Upstream feeder of the Chase flip-syndrome stage.
- Takes the two least-reliable bit positions and computes the odd-power flip terms alpha^p, alpha^3p, alpha^5p and alpha^7p for each position, over the field selected by i_code.
- Holds the results stable with a level valid. The downstream stage squares them into the even terms and forms the test-pattern syndromes.

Parameters:
- M_MAX, 10, width of field-element and position buses.
- EXP_BITS, 10, exponent bits processed by square-and-multiply.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_code  in  2  field select, latched on start:
  - 00 = GF(2^6), poly 0x43.
  - 01 = GF(2^8), poly 0x11D.
  - 10 = GF(2^10), poly 0x409.
  - 11 = treated as 10.
- i_start  in  1  one-cycle pulse: begin computation with i_pos1/i_pos2.
- i_clear  in  1  drop valid and return to IDLE.
- i_pos1  in  10  first flip position (exponent).
- i_pos2  in  10  second flip position (exponent).
- o_flip_alpha_S1_1, o_flip_alpha_S3_1, o_flip_alpha_S5_1, o_flip_alpha_S7_1  out  10 each  alpha^(k*pos1), k = 1,3,5,7.
- o_flip_alpha_S1_2, o_flip_alpha_S3_2, o_flip_alpha_S5_2, o_flip_alpha_S7_2  out  10 each  alpha^(k*pos2).
- o_flip_alpha_valid  out  1  results valid (level).
- o_busy  out  1  computation in progress.

Behaviour:
- Reset: state IDLE; all outputs 0; internal registers 0.
- Field elements: live in the low m bits, upper bits are always 0. Products are polynomial multiply reduced by the selected primitive poly, in one combinational gf multiplier per datapath use. Two identical datapaths run in lockstep, one per position.
- IDLE:
  - i_start=1 -> latch i_code and both positions, acc=1, bit index=9, go to EXP.
  - i_clear is ignored.
- EXP (10 cycles, MSB first): each cycle acc <= acc^2 * (pos[bit] ? alpha : 1), then bit index decrements. After bit 0 go to ODD1.
  - Full 10-bit exponent is used with no modular reduction of pos; alpha^(2^m-1)=1 makes this correct automatically (pos=63 in GF(2^6) gives 1).
- ODD1: r2 <= acc^2.
- ODD2: r3 <= acc*r2.
- ODD3: r5 <= r3*r2.
- ODD4: r7 <= r5*r2. Then go to DONE and set o_flip_alpha_valid <= 1.
- Latency: valid rises on the 14th rising edge after the edge that samples i_start.
- DONE:
  - Outputs are S1=acc, S3=r3, S5=r5, S7=r7, held constant.
  - S5 and S7 outputs are forced to 0 when the latched code is not 10.
  - Valid stays high until i_clear or i_start. Downstream needs valid held at least 2 cycles for its one-cycle-delayed even terms.
- o_busy = 1 in EXP and ODD1-4, else 0.
- Outputs are 0 whenever valid is 0.
- i_start while busy: ignored; the computation continues unchanged.
- i_start in DONE: valid and outputs drop to 0 next cycle, new inputs are latched, go to EXP (restart). This takes precedence over i_clear in the same cycle.
- i_clear in DONE (no start): go to IDLE, valid 0.
- i_clear while busy: abort to IDLE, outputs 0.
- Reset mid-operation: IDLE, all outputs 0 on the next edge.
- i_code changes after start have no effect until the next start.

Test Plan:
- code=00, pos1=6, pos2=0, start -> after 14 edges valid=1; S1_1=0x003, S3_1=0x00F, S1_2=S3_2=0x001, S5/S7 = 0; valid holds until i_clear, then 0 on the next cycle.
- code=10, pos1=10, pos2=1023 -> S1_1=0x009, S3_1=0x249, S5_1=0x10D; S1_2=S3_2=S5_2=S7_2=0x001.
- code=01, pos1=8, pos2=1 -> S1_1=0x01D, S1_2=0x002, S3_2=0x008; S5/S7 = 0; o_busy high for exactly 14 cycles.
- code=00, pos1=63 -> S1_1=0x001 (exponent wrap-around); i_start pulsed during EXP -> ignored, result unchanged, latency still 14.
- Result in DONE, i_start with code=10, pos1=10 -> valid low next cycle, new results after 14 edges; i_clear at cycle 5 of a run -> IDLE, valid never rises.
- Reset asserted during ODD2 -> all outputs 0 and o_busy 0 after the edge; a following start completes normally.
